// File: rtl/pcs_scrambler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcs_scrambler_pkg
// Purpose  : Shared constants for the 64b/66b-style self-synchronising
//            scrambler G(x) = 1 + x^39 + x^58.
//            Holds the tap positions, history width, reset seed, the legal
//            word widths and the bit-counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcs_scrambler_pkg;

  localparam int TAP_A  = 39;
  localparam int TAP_B  = 58;
  localparam int HIST_W = 58;

  typedef logic [HIST_W-1:0] hist_t;

  localparam hist_t SEED = 58'h3FF_FFFF_FFFF_FFFF;

  // Legal DATA_WIDTH values
  localparam int WIDTH_32 = 32;
  localparam int WIDTH_64 = 64;

  // Bit counter only needs to reach HIST_W plus one word without wrapping
  localparam int CNT_W = 7;

  function automatic bit is_legal_width(input int w);
    return (w == WIDTH_32) || (w == WIDTH_64);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_scrambler_core.sv
`default_nettype none
// ============================================================================
// Module   : pcs_scrambler_core
// Purpose  : Purely combinational scrambler/descrambler datapath. Maps the
//            58-bit history plus one input word to the output word and the
//            next history.
// Ports    : history      - last 58 scrambled-domain bits, bit 57 newest
//            word         - input word, bit 0 first on the line
//            bypass       - pass word through untouched
//            out_word     - processed word
//            next_history - history after this word is absorbed
// Revision : 1.0 - initial release
// ============================================================================
module pcs_scrambler_core
  import pcs_scrambler_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter bit DESCRAMBLE = 1'b1
) (
  input  logic [HIST_W-1:0]     history,
  input  logic [DATA_WIDTH-1:0] word,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] out_word,
  output logic [HIST_W-1:0]     next_history
);

  localparam int EXT_W = HIST_W + DATA_WIDTH;

  // The stream is laid out as ext[k] = s[k - HIST_W]: the history occupies
  // the low bits and the new word's scrambled-domain bits are appended above.
  // Bit n of the word then sees s[n-39] at ext[n+19] and s[n-58] at ext[n].
  // Because n+19 < n+58, scramble mode only ever reads bits already produced
  // earlier in the same loop, so the unrolled chain is acyclic.
  always_comb begin : comb_core
    logic [EXT_W-1:0] ext;
    logic             sbit;
    ext          = '0;
    sbit         = 1'b0;
    out_word     = '0;
    ext[HIST_W-1:0] = history;
    for (int n = 0; n < DATA_WIDTH; n++) begin
      sbit = word[n] ^ ext[n + TAP_B - TAP_A] ^ ext[n];
      out_word[n] = bypass ? word[n] : sbit;
      // Line-side bit: the received word when descrambling, the produced
      // word when scrambling; in bypass both are the raw input.
      ext[n + HIST_W] = (DESCRAMBLE || bypass) ? word[n] : sbit;
    end
    next_history = ext[EXT_W-1 -: HIST_W];
  end

endmodule
`default_nettype wire

// File: rtl/pcs_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : pcs_scrambler
// Purpose  : Self-synchronising PCS scrambler/descrambler, G(x)=1+x^39+x^58.
//            Owns the history register, saturating bit counter, valid
//            pipeline and lock indication; datapath lives in the core.
// Ports    : i_clk       - PCS clock
//            i_reset     - synchronous active-high reset
//            i_init_done - transceiver ready; low holds the block in reset
//            i_valid     - qualifies i_data (low on gearbox pauses)
//            i_data      - input word, bit 0 first
//            i_bypass    - pass data through unscrambled
//            o_valid     - qualifies o_data
//            o_data      - processed word, bit 0 first
//            o_locked    - at least 58 valid bits absorbed
// Revision : 1.0 - initial release
// ============================================================================
module pcs_scrambler
  import pcs_scrambler_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter bit DESCRAMBLE = 1'b1,
  parameter bit OUTPUT_REG = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_init_done,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_bypass,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_locked
);

  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LOCK_BITS = CNT_W'(HIST_W);

  if (!is_legal_width(DATA_WIDTH)) begin : g_bad_width
    $error("pcs_scrambler: DATA_WIDTH must be 32 or 64");
  end

  hist_t                  history;
  hist_t                  next_history;
  logic [CNT_W-1:0]       bit_count;
  logic [DATA_WIDTH-1:0]  out_word;
  logic                   flush;
  logic                   accept;

  // Dropping init_done behaves exactly like reset.
  assign flush  = i_reset || !i_init_done;
  assign accept = i_valid && i_init_done;

  pcs_scrambler_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DESCRAMBLE (DESCRAMBLE)
  ) u_core (
    .history      (history),
    .word         (i_data),
    .bypass       (i_bypass),
    .out_word     (out_word),
    .next_history (next_history)
  );

  // History, lock counter and lock flag. flush has priority, so a word
  // presented together with reset is discarded.
  always_ff @(posedge i_clk) begin
    if (flush) begin
      history   <= SEED;
      bit_count <= '0;
      o_locked  <= 1'b0;
    end else begin
      if (accept) begin
        history <= next_history;
        // Stop counting once lock is reached: the counter saturates.
        if (bit_count < LOCK_BITS) begin
          bit_count <= bit_count + WORD_BITS;
        end
      end
      if (bit_count >= LOCK_BITS) begin
        o_locked <= 1'b1;
      end
    end
  end

  if (OUTPUT_REG) begin : g_out_reg
    always_ff @(posedge i_clk) begin
      if (flush) begin
        o_valid <= 1'b0;
        o_data  <= '0;
      end else begin
        o_valid <= accept;
        // Data holds its last value across pause cycles.
        if (accept) begin
          o_data <= out_word;
        end
      end
    end
  end else begin : g_out_comb
    assign o_valid = i_valid && i_init_done;
    assign o_data  = out_word;
  end

endmodule
`default_nettype wire

// File: tb/tb_pcs_scrambler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_scrambler
// Purpose  : Directed self-checking bench for pcs_scrambler. Instances:
//            64-bit descrambler (registered and combinational output),
//            32-bit descrambler, and a 64-bit scrambler feeding a 64-bit
//            descrambler for the round-trip run.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_scrambler;

  localparam logic [63:0] ZW1     = 64'h03FF_FF80_0000_0000;
  localparam logic [63:0] SCR_ZW2 = 64'hFFEF_FFFF_FFFF_C000;
  localparam logic [63:0] BYP_VAL = 64'hDEAD_BEEF_0123_4567;

  logic        clk = 1'b0;
  logic        rst;
  logic        init;

  logic        d_valid, d_bypass;
  logic [63:0] d_data;
  logic        n_valid;
  logic [31:0] n_data;
  logic        s_valid;
  logic [63:0] s_data;

  logic        d64_valid, d64_locked;
  logic [63:0] d64_data;
  logic        dc_valid, dc_locked;
  logic [63:0] dc_data;
  logic        n32_valid, n32_locked;
  logic [31:0] n32_data;
  logic        scr_valid, scr_locked;
  logic [63:0] scr_data;
  logic        rx_valid, rx_locked;
  logic [63:0] rx_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] rt_d [0:1199];
  logic        rt_v [0:1199];
  int          rt_i;
  int          rt_sent;

  always #5 clk = ~clk;

  pcs_scrambler #(.DATA_WIDTH(64), .DESCRAMBLE(1'b1), .OUTPUT_REG(1'b1)) u_d64 (
    .i_clk(clk), .i_reset(rst), .i_init_done(init), .i_valid(d_valid),
    .i_data(d_data), .i_bypass(d_bypass), .o_valid(d64_valid),
    .o_data(d64_data), .o_locked(d64_locked));

  pcs_scrambler #(.DATA_WIDTH(64), .DESCRAMBLE(1'b1), .OUTPUT_REG(1'b0)) u_dcomb (
    .i_clk(clk), .i_reset(rst), .i_init_done(init), .i_valid(d_valid),
    .i_data(d_data), .i_bypass(d_bypass), .o_valid(dc_valid),
    .o_data(dc_data), .o_locked(dc_locked));

  pcs_scrambler #(.DATA_WIDTH(32), .DESCRAMBLE(1'b1), .OUTPUT_REG(1'b1)) u_d32 (
    .i_clk(clk), .i_reset(rst), .i_init_done(init), .i_valid(n_valid),
    .i_data(n_data), .i_bypass(1'b0), .o_valid(n32_valid),
    .o_data(n32_data), .o_locked(n32_locked));

  pcs_scrambler #(.DATA_WIDTH(64), .DESCRAMBLE(1'b0), .OUTPUT_REG(1'b1)) u_scr (
    .i_clk(clk), .i_reset(rst), .i_init_done(init), .i_valid(s_valid),
    .i_data(s_data), .i_bypass(1'b0), .o_valid(scr_valid),
    .o_data(scr_data), .o_locked(scr_locked));

  pcs_scrambler #(.DATA_WIDTH(64), .DESCRAMBLE(1'b1), .OUTPUT_REG(1'b1)) u_rx (
    .i_clk(clk), .i_reset(rst), .i_init_done(init), .i_valid(scr_valid),
    .i_data(scr_data), .i_bypass(1'b0), .o_valid(rx_valid),
    .o_data(rx_data), .o_locked(rx_locked));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; init = 1'b1;
    d_valid = 1'b0; d_bypass = 1'b0; d_data = '0;
    n_valid = 1'b0; n_data = '0;
    s_valid = 1'b0; s_data = '0;

    // Reset state
    step(); step();
    check("rst_valid",  {63'd0, d64_valid},  64'd0);
    check("rst_data",   d64_data,            64'd0);
    check("rst_locked", {63'd0, d64_locked}, 64'd0);
    check("rst_scr_valid", {63'd0, scr_valid}, 64'd0);
    check("rst_n32_data",  {32'd0, n32_data},  64'd0);
    rst = 1'b0;

    // First zero word from the seed
    d_valid = 1'b1; d_data = '0;
    #1;
    check("comb_valid_first", {63'd0, dc_valid}, 64'd1);
    check("comb_data_first",  dc_data,           ZW1);
    step();
    check("first_valid",  {63'd0, d64_valid},  64'd1);
    check("first_data",   d64_data,            ZW1);
    check("first_locked", {63'd0, d64_locked}, 64'd0);
    d_valid = 1'b0;
    step();
    check("pause_valid",  {63'd0, d64_valid},  64'd0);
    check("pause_hold",   d64_data,            ZW1);
    check("lock_after_1", {63'd0, d64_locked}, 64'd1);
    check("comb_pause_valid", {63'd0, dc_valid}, 64'd0);

    // History now all zero, pause did not disturb it
    d_valid = 1'b1; d_data = '0;
    step();
    check("second_word", d64_data, 64'd0);

    // Reset together with a valid word: word discarded
    d_data = 64'h1234_5678_9ABC_DEF0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid",  {63'd0, d64_valid},  64'd0);
    check("midrst_locked", {63'd0, d64_locked}, 64'd0);
    check("midrst_data",   d64_data,            64'd0);
    d_data = '0;
    step();
    check("post_rst_valid", {63'd0, d64_valid}, 64'd1);
    check("post_rst_data",  d64_data,           ZW1);
    d_valid = 1'b0;
    step();
    check("post_rst_lock", {63'd0, d64_locked}, 64'd1);

    // init_done low mid-stream behaves as reset
    init = 1'b0; d_valid = 1'b1; d_data = 64'hFFFF_0000_FFFF_0000;
    #1;
    check("init_comb_valid", {63'd0, dc_valid}, 64'd0);
    step();
    check("init_valid",  {63'd0, d64_valid},  64'd0);
    check("init_locked", {63'd0, d64_locked}, 64'd0);
    init = 1'b1; d_data = '0;
    step();
    check("init_reseed", d64_data, ZW1);

    // Bypass from a fresh seed
    d_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    d_bypass = 1'b1; d_valid = 1'b1; d_data = BYP_VAL;
    #1;
    check("byp_comb", dc_data, BYP_VAL);
    step();
    check("byp_reg", d64_data, BYP_VAL);
    d_data = '0;
    step();
    check("byp_zero", d64_data, 64'd0);
    d_bypass = 1'b0;
    step();
    check("byp_hist", d64_data, 64'd0);
    d_valid = 1'b0;

    // 32-bit descrambler lock after two words
    n_valid = 1'b1; n_data = '0;
    step();
    check("w32_first",      {32'd0, n32_data},   64'd0);
    check("w32_first_lock", {63'd0, n32_locked}, 64'd0);
    n_valid = 1'b0;
    step();
    check("w32_idle_lock",  {63'd0, n32_locked}, 64'd0);
    n_valid = 1'b1;
    step();
    check("w32_second", {32'd0, n32_data}, 64'h0000_0000_03FF_FF80);
    n_valid = 1'b0;
    step();
    check("w32_lock", {63'd0, n32_locked}, 64'd1);

    // Scrambler: two zero words from the seed
    s_valid = 1'b1; s_data = '0;
    step();
    check("scr_word1", scr_data, ZW1);
    step();
    check("scr_word2", scr_data, SCR_ZW2);
    check("rx_word1",  rx_data,  64'd0);
    s_valid = 1'b0;

    // Round trip with a gearbox pause every 33rd cycle
    rst = 1'b1;
    step();
    rst = 1'b0;
    rt_i = 0;
    rt_sent = 0;
    while (rt_sent < 1000 && rt_i < 1199) begin
      s_valid = (rt_i % 33) != 32;
      s_data  = {$urandom, $urandom};
      rt_v[rt_i] = s_valid;
      rt_d[rt_i] = s_data;
      if (s_valid) rt_sent++;
      step();
      if (rt_i > 0) begin
        check("rt_valid", {63'd0, rx_valid}, {63'd0, rt_v[rt_i-1]});
        if (rt_v[rt_i-1]) check("rt_data", rx_data, rt_d[rt_i-1]);
      end
      rt_i++;
    end
    s_valid = 1'b0;
    step();
    check("rt_valid_last", {63'd0, rx_valid}, {63'd0, rt_v[rt_i-1]});
    if (rt_v[rt_i-1]) check("rt_data_last", rx_data, rt_d[rt_i-1]);
    check("rt_locked", {63'd0, rx_locked}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
